ex_operand_forward: RTL and testbench

- Parametrised ID/EX operand stage for the pipelined core.
- Holds the EX-stage source operands and resolves MEM/WB forwarding for ALU input 1, ALU input 2 and store data.
- Detects load-use hazards and inserts a bubble.
- While EX is held, captures forwarded values into its operand registers, so data from producers that retire during the hold is not lost.

---
 rtl/ex_operand_forward_if.sv | 57 +++++
 rtl/ex_operand_forward.sv | 133 +++++++++++++
 tb/tb_ex_operand_forward.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_operand_forward_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_forward_if
// Brief    : ID/EX operand-stage bus: ID fields, MEM/WB producers, EX outputs.
// Revision : 1.0
// ============================================================================
interface ex_operand_forward_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            id_alu_src;
    logic            id_reg_write;
    logic            id_is_load;
    logic            mem_reg_write;
    logic [RA_W-1:0] mem_rd;
    logic [XLEN-1:0] mem_rd_data;
    logic            wb_reg_write;
    logic [RA_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_hold;
    logic            flush;
    logic            ex_valid;
    logic [RA_W-1:0] ex_rd;
    logic            ex_reg_write;
    logic [XLEN-1:0] ex_alu_in1;
    logic [XLEN-1:0] ex_alu_in2;
    logic [XLEN-1:0] ex_store_data;
    logic [1:0]      ex_fwd_a;
    logic [1:0]      ex_fwd_b;
    logic            load_use_stall;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_alu_src, id_reg_write, id_is_load,
               mem_reg_write, mem_rd, mem_rd_data, wb_reg_write, wb_rd, wb_data,
               ex_hold, flush,
        input  ex_valid, ex_rd, ex_reg_write, ex_alu_in1, ex_alu_in2, ex_store_data,
               ex_fwd_a, ex_fwd_b, load_use_stall
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_alu_src, id_reg_write, id_is_load,
               mem_reg_write, mem_rd, mem_rd_data, wb_reg_write, wb_rd, wb_data,
               ex_hold, flush,
        output ex_valid, ex_rd, ex_reg_write, ex_alu_in1, ex_alu_in2, ex_store_data,
               ex_fwd_a, ex_fwd_b, load_use_stall
    );
endinterface
`default_nettype wire

// File: rtl/ex_operand_forward.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_forward
// Brief    : EX operand registers with MEM/WB forwarding, hold-capture and
//            load-use bubble insertion.
// Revision : 1.0
// ============================================================================
module ex_operand_forward #(
    parameter int XLEN       = 32,
    parameter int RA_W       = 5,
    parameter int FWD_MEM_EN = 1,
    parameter int FWD_WB_EN  = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    ex_operand_forward_if.slave bus
);
    localparam logic [1:0] c_sel_reg = 2'b00;
    localparam logic [1:0] c_sel_wb  = 2'b01;
    localparam logic [1:0] c_sel_mem = 2'b10;

    logic            r_valid;
    logic            r_reg_write;
    logic            r_is_load;
    logic            r_alu_src;
    logic [RA_W-1:0] r_rs1;
    logic [RA_W-1:0] r_rs2;
    logic [RA_W-1:0] r_rd;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [XLEN-1:0] r_imm;

    logic            w_mem_ok;
    logic            w_wb_ok;
    logic [1:0]      w_fwd_a;
    logic [1:0]      w_fwd_b;
    logic [XLEN-1:0] w_val_a;
    logic [XLEN-1:0] w_val_b;
    logic            w_load_use;

    // A producer writing x0 is never a forwarding source.
    generate
        if (FWD_MEM_EN != 0) begin : g_mem_on
            assign w_mem_ok = bus.mem_reg_write & (bus.mem_rd != '0);
        end else begin : g_mem_off
            assign w_mem_ok = 1'b0;
        end
        if (FWD_WB_EN != 0) begin : g_wb_on
            assign w_wb_ok = bus.wb_reg_write & (bus.wb_rd != '0);
        end else begin : g_wb_off
            assign w_wb_ok = 1'b0;
        end
    endgenerate

    function automatic logic [1:0] f_select(
        input logic            valid,
        input logic [RA_W-1:0] src,
        input logic            mem_ok,
        input logic [RA_W-1:0] mem_rd,
        input logic            wb_ok,
        input logic [RA_W-1:0] wb_rd
    );
        if (!valid)                         return c_sel_reg;
        else if (mem_ok && (mem_rd == src)) return c_sel_mem;
        else if (wb_ok && (wb_rd == src))   return c_sel_wb;
        else                                return c_sel_reg;
    endfunction

    function automatic logic [XLEN-1:0] f_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] reg_val,
        input logic [XLEN-1:0] mem_val,
        input logic [XLEN-1:0] wb_val
    );
        case (sel)
            c_sel_mem: return mem_val;
            c_sel_wb:  return wb_val;
            default:   return reg_val;
        endcase
    endfunction

    assign w_fwd_a = f_select(r_valid, r_rs1, w_mem_ok, bus.mem_rd, w_wb_ok, bus.wb_rd);
    assign w_fwd_b = f_select(r_valid, r_rs2, w_mem_ok, bus.mem_rd, w_wb_ok, bus.wb_rd);
    assign w_val_a = f_mux(w_fwd_a, r_op1, bus.mem_rd_data, bus.wb_data);
    assign w_val_b = f_mux(w_fwd_b, r_op2, bus.mem_rd_data, bus.wb_data);

    // Conservative: any source match stalls, even if that source is unused.
    assign w_load_use = r_valid & r_is_load & r_reg_write & (r_rd != '0) & bus.id_valid &
                        ((bus.id_rs1 == r_rd) | (bus.id_rs2 == r_rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_is_load   <= 1'b0;
            r_alu_src   <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_imm       <= '0;
        end else if (bus.ex_hold) begin
            // Producers retire during a hold; latch what they forward so it survives.
            if (w_fwd_a != c_sel_reg) r_op1 <= w_val_a;
            if (w_fwd_b != c_sel_reg) r_op2 <= w_val_b;
        end else if (bus.flush || w_load_use) begin
            r_valid <= 1'b0;
        end else begin
            r_valid     <= bus.id_valid;
            r_reg_write <= bus.id_reg_write;
            r_is_load   <= bus.id_is_load;
            r_alu_src   <= bus.id_alu_src;
            r_rs1       <= bus.id_rs1;
            r_rs2       <= bus.id_rs2;
            r_rd        <= bus.id_rd;
            r_op1       <= bus.id_rs1_data;
            r_op2       <= bus.id_rs2_data;
            r_imm       <= bus.id_imm;
        end
    end

    assign bus.ex_valid       = r_valid;
    assign bus.ex_rd          = r_rd;
    assign bus.ex_reg_write   = r_valid & r_reg_write;
    assign bus.ex_fwd_a       = w_fwd_a;
    assign bus.ex_fwd_b       = w_fwd_b;
    assign bus.ex_alu_in1     = w_val_a;
    assign bus.ex_store_data  = w_val_b;
    assign bus.ex_alu_in2     = r_alu_src ? r_imm : w_val_b;
    assign bus.load_use_stall = w_load_use;
endmodule
`default_nettype wire

// File: tb/tb_ex_operand_forward.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_operand_forward
// Brief    : Directed plus random bench; three DUT variants share one stimulus.
// Revision : 1.0
// ============================================================================
module tb_ex_operand_forward;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_operand_forward_if #(.XLEN(32), .RA_W(5)) if0 ();
    ex_operand_forward_if #(.XLEN(32), .RA_W(5)) if1 ();
    ex_operand_forward_if #(.XLEN(64), .RA_W(5)) if2 ();

    ex_operand_forward #(.XLEN(32), .RA_W(5), .FWD_MEM_EN(1), .FWD_WB_EN(1))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    ex_operand_forward #(.XLEN(32), .RA_W(5), .FWD_MEM_EN(0), .FWD_WB_EN(1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    ex_operand_forward #(.XLEN(64), .RA_W(5), .FWD_MEM_EN(1), .FWD_WB_EN(1))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    assign if1.id_valid      = if0.id_valid;
    assign if1.id_rs1        = if0.id_rs1;
    assign if1.id_rs2        = if0.id_rs2;
    assign if1.id_rd         = if0.id_rd;
    assign if1.id_rs1_data   = if0.id_rs1_data;
    assign if1.id_rs2_data   = if0.id_rs2_data;
    assign if1.id_imm        = if0.id_imm;
    assign if1.id_alu_src    = if0.id_alu_src;
    assign if1.id_reg_write  = if0.id_reg_write;
    assign if1.id_is_load    = if0.id_is_load;
    assign if1.mem_reg_write = if0.mem_reg_write;
    assign if1.mem_rd        = if0.mem_rd;
    assign if1.mem_rd_data   = if0.mem_rd_data;
    assign if1.wb_reg_write  = if0.wb_reg_write;
    assign if1.wb_rd         = if0.wb_rd;
    assign if1.wb_data       = if0.wb_data;
    assign if1.ex_hold       = if0.ex_hold;
    assign if1.flush         = if0.flush;

    // Wide variant sees {~x, x} so both halves carry distinct data.
    assign if2.id_valid      = if0.id_valid;
    assign if2.id_rs1        = if0.id_rs1;
    assign if2.id_rs2        = if0.id_rs2;
    assign if2.id_rd         = if0.id_rd;
    assign if2.id_rs1_data   = {~if0.id_rs1_data, if0.id_rs1_data};
    assign if2.id_rs2_data   = {~if0.id_rs2_data, if0.id_rs2_data};
    assign if2.id_imm        = {~if0.id_imm, if0.id_imm};
    assign if2.id_alu_src    = if0.id_alu_src;
    assign if2.id_reg_write  = if0.id_reg_write;
    assign if2.id_is_load    = if0.id_is_load;
    assign if2.mem_reg_write = if0.mem_reg_write;
    assign if2.mem_rd        = if0.mem_rd;
    assign if2.mem_rd_data   = {~if0.mem_rd_data, if0.mem_rd_data};
    assign if2.wb_reg_write  = if0.wb_reg_write;
    assign if2.wb_rd         = if0.wb_rd;
    assign if2.wb_data       = {~if0.wb_data, if0.wb_data};
    assign if2.ex_hold       = if0.ex_hold;
    assign if2.flush         = if0.flush;

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction sitting in EX; operand values per variant
    // (index 0: MEM+WB forwarding, index 1: WB only).
    logic        m_valid, m_rw, m_ld, m_as;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_imm;
    logic [31:0] m_op1 [2];
    logic [31:0] m_op2 [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wide(input logic [31:0] x);
        return {~x, x};
    endfunction

    // Youngest older producer of src, or 0 if the register file value stands.
    function automatic logic [1:0] exp_sel(input int v, input logic [4:0] src);
        if (!m_valid) return 2'd0;
        if (v == 0 && if0.mem_reg_write && if0.mem_rd != 5'd0 && if0.mem_rd == src) return 2'd2;
        if (if0.wb_reg_write && if0.wb_rd != 5'd0 && if0.wb_rd == src) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] exp_val(input logic [1:0] s, input logic [31:0] r);
        if (s == 2'd2) return if0.mem_rd_data;
        if (s == 2'd1) return if0.wb_data;
        return r;
    endfunction

    function automatic logic exp_lu();
        return m_valid && m_ld && m_rw && m_rd != 5'd0 && if0.id_valid &&
               (if0.id_rs1 == m_rd || if0.id_rs2 == m_rd);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_ld = 0; m_as = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_imm = 0;
        for (int v = 0; v < 2; v++) begin
            m_op1[v] = 0;
            m_op2[v] = 0;
        end
    endtask

    task automatic model_update();
        logic lu;
        lu = exp_lu();
        if (!rst_n) begin
            model_reset();
        end else if (if0.ex_hold) begin
            for (int v = 0; v < 2; v++) begin
                m_op1[v] = exp_val(exp_sel(v, m_rs1), m_op1[v]);
                m_op2[v] = exp_val(exp_sel(v, m_rs2), m_op2[v]);
            end
        end else if (if0.flush || lu) begin
            m_valid = 0;
        end else begin
            m_valid = if0.id_valid; m_rw = if0.id_reg_write; m_ld = if0.id_is_load;
            m_as = if0.id_alu_src; m_rs1 = if0.id_rs1; m_rs2 = if0.id_rs2;
            m_rd = if0.id_rd; m_imm = if0.id_imm;
            for (int v = 0; v < 2; v++) begin
                m_op1[v] = if0.id_rs1_data;
                m_op2[v] = if0.id_rs2_data;
            end
        end
    endtask

    task automatic check_all();
        logic [1:0]  ea, eb, oa, ob;
        logic [31:0] e1, esd, e2, o1, osd, o2;
        chk("ex_valid", {63'd0, if0.ex_valid}, {63'd0, m_valid});
        chk("ex_reg_write", {63'd0, if0.ex_reg_write}, {63'd0, m_valid & m_rw});
        chk("load_use_stall", {63'd0, if0.load_use_stall}, {63'd0, exp_lu()});
        if (m_valid) chk("ex_rd", {59'd0, if0.ex_rd}, {59'd0, m_rd});
        for (int v = 0; v < 2; v++) begin
            ea  = exp_sel(v, m_rs1);
            eb  = exp_sel(v, m_rs2);
            e1  = exp_val(ea, m_op1[v]);
            esd = exp_val(eb, m_op2[v]);
            e2  = m_as ? m_imm : esd;
            oa  = (v == 0) ? if0.ex_fwd_a : if1.ex_fwd_a;
            ob  = (v == 0) ? if0.ex_fwd_b : if1.ex_fwd_b;
            o1  = (v == 0) ? if0.ex_alu_in1 : if1.ex_alu_in1;
            osd = (v == 0) ? if0.ex_store_data : if1.ex_store_data;
            o2  = (v == 0) ? if0.ex_alu_in2 : if1.ex_alu_in2;
            chk($sformatf("fwd_a[%0d]", v), {62'd0, oa}, {62'd0, ea});
            chk($sformatf("fwd_b[%0d]", v), {62'd0, ob}, {62'd0, eb});
            if (m_valid) begin
                chk($sformatf("alu_in1[%0d]", v), {32'd0, o1}, {32'd0, e1});
                chk($sformatf("store_data[%0d]", v), {32'd0, osd}, {32'd0, esd});
                chk($sformatf("alu_in2[%0d]", v), {32'd0, o2}, {32'd0, e2});
                if (v == 0) begin
                    chk("alu_in1_64", if2.ex_alu_in1, wide(e1));
                    chk("store_data_64", if2.ex_store_data, wide(esd));
                    chk("alu_in2_64", if2.ex_alu_in2, wide(e2));
                end
            end
        end
    endtask

    // Caller sets inputs just after a negedge; outputs are checked, then the edge taken.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        if0.id_valid = 0; if0.id_rs1 = 0; if0.id_rs2 = 0; if0.id_rd = 0;
        if0.id_rs1_data = 0; if0.id_rs2_data = 0; if0.id_imm = 0;
        if0.id_alu_src = 0; if0.id_reg_write = 0; if0.id_is_load = 0;
        if0.mem_reg_write = 0; if0.mem_rd = 0; if0.mem_rd_data = 0;
        if0.wb_reg_write = 0; if0.wb_rd = 0; if0.wb_data = 0;
        if0.ex_hold = 0; if0.flush = 0;
    endtask

    task automatic load(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                        input logic [31:0] d2, input logic [4:0] rd, input logic [31:0] imm,
                        input logic as, input logic ld);
        idle();
        if0.id_valid = 1; if0.id_rs1 = rs1; if0.id_rs1_data = d1;
        if0.id_rs2 = rs2; if0.id_rs2_data = d2; if0.id_rd = rd; if0.id_imm = imm;
        if0.id_alu_src = as; if0.id_reg_write = 1; if0.id_is_load = ld;
        tick();
    endtask

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {63'd0, if0.ex_valid}, 64'd0);
        chk("rst_fwd_a", {62'd0, if0.ex_fwd_a}, 64'd0);
        chk("rst_lu", {63'd0, if0.load_use_stall}, 64'd0);
        chk("rst_alu_in1", {32'd0, if0.ex_alu_in1}, 64'd0);
        chk("rst_alu_in2_64", if2.ex_alu_in2, 64'd0);
        rst_n = 1;
        @(negedge clk);

        // MEM beats WB on the same register; WB-only variant takes WB.
        load(5'd5, 32'h11, 5'd6, 32'h66, 5'd1, 32'h0, 0, 0);
        idle();
        if0.mem_reg_write = 1; if0.mem_rd = 5'd5; if0.mem_rd_data = 32'hAAAA0001;
        if0.wb_reg_write = 1; if0.wb_rd = 5'd5; if0.wb_data = 32'hBBBB0002;
        #1;
        chk("prio_fwd_a", {62'd0, if0.ex_fwd_a}, 64'd2);
        chk("prio_in1", {32'd0, if0.ex_alu_in1}, 64'h0000_0000_AAAA_0001);
        chk("nomem_fwd_a", {62'd0, if1.ex_fwd_a}, 64'd1);
        chk("nomem_in1", {32'd0, if1.ex_alu_in1}, 64'h0000_0000_BBBB_0002);
        chk("wide_in1", if2.ex_alu_in1, 64'h5555_FFFE_AAAA_0001);
        tick();

        // x0 is never forwarded.
        load(5'd0, 32'h22, 5'd6, 32'h0, 5'd1, 32'h0, 0, 0);
        idle();
        if0.mem_reg_write = 1; if0.mem_rd = 5'd0; if0.mem_rd_data = 32'hAAAA0001;
        if0.wb_reg_write = 1; if0.wb_rd = 5'd0; if0.wb_data = 32'hBBBB0002;
        #1;
        chk("x0_fwd_a", {62'd0, if0.ex_fwd_a}, 64'd0);
        chk("x0_in1", {32'd0, if0.ex_alu_in1}, 64'h22);
        tick();

        // Immediate goes to ALU input 2; store data still forwarded.
        load(5'd1, 32'h0, 5'd7, 32'h99, 5'd2, 32'h10, 1, 0);
        idle();
        if0.wb_reg_write = 1; if0.wb_rd = 5'd7; if0.wb_data = 32'h55;
        #1;
        chk("split_in2", {32'd0, if0.ex_alu_in2}, 64'h10);
        chk("split_store", {32'd0, if0.ex_store_data}, 64'h55);
        chk("split_fwd_b", {62'd0, if0.ex_fwd_b}, 64'd1);
        tick();

        // Load to x3 in EX, consumer of x3 in ID.
        load(5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 32'h0, 0, 1);
        idle();
        if0.id_valid = 1; if0.id_rs1 = 5'd3; if0.id_rd = 5'd4; if0.id_reg_write = 1;
        #1;
        chk("lu_stall", {63'd0, if0.load_use_stall}, 64'd1);
        tick();
        if0.mem_reg_write = 1; if0.mem_rd = 5'd3; if0.mem_rd_data = 32'h777;
        #1;
        chk("lu_bubble", {63'd0, if0.ex_valid}, 64'd0);
        chk("lu_released", {63'd0, if0.load_use_stall}, 64'd0);
        tick();
        if0.id_valid = 0;
        #1;
        chk("lu_consumer_valid", {63'd0, if0.ex_valid}, 64'd1);
        chk("lu_consumer_fwd_a", {62'd0, if0.ex_fwd_a}, 64'd2);
        chk("lu_consumer_in1", {32'd0, if0.ex_alu_in1}, 64'h777);
        tick();

        // Three-cycle hold while the producer of x9 passes MEM, WB and retires.
        load(5'd0, 32'h0, 5'd9, 32'h0, 5'd5, 32'h0, 0, 0);
        idle();
        if0.ex_hold = 1; if0.mem_reg_write = 1; if0.mem_rd = 5'd9; if0.mem_rd_data = 32'h1234;
        #1;
        chk("hold_mem_fwd_b", {62'd0, if0.ex_fwd_b}, 64'd2);
        tick();
        idle();
        if0.ex_hold = 1; if0.wb_reg_write = 1; if0.wb_rd = 5'd9; if0.wb_data = 32'h1234;
        #1;
        chk("hold_wb_fwd_b", {62'd0, if0.ex_fwd_b}, 64'd1);
        tick();
        idle();
        if0.ex_hold = 1;
        tick();
        idle();
        #1;
        chk("hold_after_store", {32'd0, if0.ex_store_data}, 64'h1234);
        chk("hold_after_fwd_b", {62'd0, if0.ex_fwd_b}, 64'd0);
        chk("hold_after_nomem", {32'd0, if1.ex_store_data}, 64'h1234);
        tick();

        // Reset arriving in the middle of a hold that already captured data.
        load(5'd2, 32'h5, 5'd0, 32'h0, 5'd6, 32'h0, 0, 0);
        idle();
        if0.ex_hold = 1; if0.mem_reg_write = 1; if0.mem_rd = 5'd2; if0.mem_rd_data = 32'hCAFE;
        tick();
        rst_n = 0;
        #1;
        chk("rst_hold_valid", {63'd0, if0.ex_valid}, 64'd0);
        chk("rst_hold_fwd_a", {62'd0, if0.ex_fwd_a}, 64'd0);
        chk("rst_hold_lu", {63'd0, if0.load_use_stall}, 64'd0);
        chk("rst_hold_in1", {32'd0, if0.ex_alu_in1}, 64'd0);
        model_reset();
        tick();
        rst_n = 1;
        idle();
        tick();

        for (int n = 0; n < 500; n++) begin
            if0.id_valid      = ($urandom_range(0, 3) != 0);
            if0.id_rs1        = 5'($urandom_range(0, 3));
            if0.id_rs2        = 5'($urandom_range(0, 3));
            if0.id_rd         = 5'($urandom_range(0, 3));
            if0.id_rs1_data   = $urandom;
            if0.id_rs2_data   = $urandom;
            if0.id_imm        = $urandom;
            if0.id_alu_src    = 1'($urandom_range(0, 1));
            if0.id_reg_write  = ($urandom_range(0, 3) != 0);
            if0.id_is_load    = ($urandom_range(0, 2) == 0);
            if0.mem_reg_write = 1'($urandom_range(0, 1));
            if0.mem_rd        = 5'($urandom_range(0, 3));
            if0.mem_rd_data   = $urandom;
            if0.wb_reg_write  = 1'($urandom_range(0, 1));
            if0.wb_rd         = 5'($urandom_range(0, 3));
            if0.wb_data       = $urandom;
            if0.ex_hold       = ($urandom_range(0, 3) == 0);
            if0.flush         = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
